traffic_conflict_monitor: RTL and testbench
===========================================

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter YEL_MIN, default 4: minimum legal yellow duration, in clk cycles.
REQ-002 Parameter DARK_LIMIT, default 3: consecutive all-dark cycles tolerated per approach.
REQ-003 Parameter FLASH_HALF, default 2: flash half-period, in clk cycles.
REQ-004 One clock; reset is synchronous and active-high. Ports: clk and rst.
REQ-005 Port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Ports ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green: inputs, 1 bit each, lamp drives observed from the controller.
REQ-008 Port fault_clr, input, 1 bit: single-cycle clear of the latched fault.
REQ-009 Port fault, output, 1 bit: latched fault flag.
REQ-010 Port fault_code, output, 3 bits: cause of the first fault.
REQ-011 Port fault_cnt, output, 8 bits: number of faults latched since reset.
REQ-012 Port flash_red, output, 1 bit: fail-safe red-flash drive.

Function
REQ-013 Each approach (NS, EW) SHALL be tracked by a state machine with states UNK, RED, GRN, YEL; the initial state is UNK.
REQ-014 From UNK, the machine SHALL enter the state of the single lit lamp, with no sequence checks applied.
REQ-015 Legal transitions SHALL be: RED->GRN, GRN->YEL, YEL->RED; holding the current state is also legal.
REQ-016 A GRN->RED transition SHALL raise a skip-yellow fault (code 4).
REQ-017 Any other illegal transition, for example YEL->GRN or RED->YEL, SHALL raise a sequence fault (code 5).
REQ-018 A YEL->RED transition after fewer than YEL_MIN YEL cycles SHALL raise a short-yellow fault (code 6); the yellow counter saturates at YEL_MIN.
REQ-019 Two or more lamps lit on one approach in one cycle SHALL raise a multi-lamp fault (code 2); the state machine holds its state that cycle.
REQ-020 Zero lamps lit SHALL hold the state and increment a dark counter.
    - A dark counter exceeding DARK_LIMIT raises a dark fault (code 3).
    - Any lit lamp resets the dark counter.
REQ-021 NS not red AND EW not red in the same cycle, with both approaches having exactly one lamp lit, SHALL raise a conflict fault (code 1).
REQ-022 All checks SHALL be evaluated from the current-cycle inputs; fault and fault_code SHALL update on the next rising edge (latency 1 cycle).
REQ-023 Multiple simultaneous causes SHALL latch the lowest code.
REQ-024 Faults raised while fault=1 SHALL NOT change fault_code or fault_cnt.
REQ-025 fault_cnt SHALL increment once per newly latched fault and saturate at 255.
REQ-026 fault_clr SHALL clear fault and fault_code and return both trackers to UNK on the next edge; fault_cnt is not cleared.
    - If a fault cause is present in the same cycle as fault_clr, the fault SHALL be latched, and fault_clr is ignored.

Reset
REQ-027 Synchronous reset SHALL set: fault=0, fault_code=0, fault_cnt=0, flash_red=0, both trackers to UNK, dark counters to 0, yellow counters to 0, and the flash counter to 0.
REQ-028 rst SHALL take priority over fault_clr and over any fault detection; reset mid-yellow SHALL discard the partial count.

Configuration
REQ-029 The feature macro SHALL be TRAFFIC_MON_FLASH_EN.
REQ-030 With TRAFFIC_MON_FLASH_EN defined: while fault=1, flash_red SHALL toggle every FLASH_HALF cycles.
    - The first toggle to 1 occurs on the edge that latches the fault.
    - While fault=0, flash_red is 0.
REQ-031 With TRAFFIC_MON_FLASH_EN undefined: flash_red SHALL be constant 0 and no flash counter SHALL be synthesised; all other behaviour is unchanged.

Structure
REQ-032 Package traffic_mon_pkg SHALL hold:
    - the lamp-state enum (UNK, RED, GRN, YEL);
    - the 3-bit fault-code constants FC_NONE=0, FC_CONFLICT=1, FC_MULTI=2, FC_DARK=3, FC_SKIPYEL=4, FC_SEQ=5, FC_SHORTYEL=6.
REQ-033 Sub-module approach_tracker SHALL implement the per-approach state machine, dark counter and yellow counter.
    - It is instantiated twice (NS, EW).
    - It emits per-approach fault strobes and an is_red flag.
REQ-034 The top level SHALL hold the conflict check, the priority encoder, the fault latch, fault_cnt and the flash generator.

Verification
REQ-035 Legal cycle: NS G(10)->Y(4)->R, EW R throughout, then EW G(10)->Y(4)->R -> fault stays 0, fault_cnt=0.
REQ-036 Both green: ns_green=1 and ew_green=1 for one cycle -> fault=1 and fault_code=1 next edge, fault_cnt=1; with the flash macro defined, flash_red toggles every 2 cycles.
REQ-037 Short yellow: NS G->Y held 3 cycles->R with YEL_MIN=4 -> fault_code=6 one cycle after red is sampled.
REQ-038 Simultaneous faults: NS G->R direct while ns_yellow is also lit -> fault_code=2, the lowest code, not 4.
REQ-039 Dark approach: EW all lamps 0 for 4 cycles -> fault_code=3 on the fourth dark cycle's edge.
    - The same case with 3 dark cycles followed by a lit lamp -> no fault.
REQ-040 Clear and reset:
    - fault_clr with no fault cause present -> fault=0 and fault_cnt retained.
    - fault_clr in the same cycle as a conflict -> fault stays 1.
    - rst mid-yellow -> all outputs 0 and trackers UNK; no short-yellow fault follows.

Source files
------------

// File: rtl/traffic_conflict_monitor_pkg.sv
// rtl/traffic_conflict_monitor_pkg.sv - lamp-state enum, fault codes and lamp decode for the traffic monitor
package traffic_mon_pkg;

    typedef enum logic [1:0] {
        UNK = 2'd0,
        RED = 2'd1,
        GRN = 2'd2,
        YEL = 2'd3
    } lamp_state_e;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_MULTI    = 3'd2;
    localparam logic [2:0] FC_DARK     = 3'd3;
    localparam logic [2:0] FC_SKIPYEL  = 3'd4;
    localparam logic [2:0] FC_SEQ      = 3'd5;
    localparam logic [2:0] FC_SHORTYEL = 3'd6;

    // Only meaningful when exactly one lamp is lit.
    function automatic lamp_state_e lamp_decode(input logic red, input logic yel, input logic grn);
        if (red)      return RED;
        else if (grn) return GRN;
        else if (yel) return YEL;
        else          return UNK;
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// rtl/traffic_conflict_monitor_if.sv - lamp observation and fault reporting bundle for the traffic monitor
interface traffic_conflict_monitor_if;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;
    logic       flash_red;

    modport master (
        output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
        input  fault, fault_code, fault_cnt, flash_red
    );

    modport slave (
        input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clr,
        output fault, fault_code, fault_cnt, flash_red
    );
endinterface

// File: rtl/traffic_conflict_monitor_tracker.sv
// rtl/traffic_conflict_monitor_tracker.sv - per-approach lamp sequence tracker with dark and yellow counters
module approach_tracker
    import traffic_mon_pkg::*;
#(
    parameter int YEL_MIN    = 4,
    parameter int DARK_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic red_i,
    input  logic yel_i,
    input  logic grn_i,
    output logic one_lit_o,
    output logic is_red_o,
    output logic multi_o,
    output logic dark_o,
    output logic skip_o,
    output logic seq_o,
    output logic short_o
);

    localparam int YW = (YEL_MIN > 0) ? $clog2(YEL_MIN + 1) : 1;
    localparam int DW = $clog2(DARK_LIMIT + 2);
    localparam logic [YW-1:0] YEL_SAT  = YW'(YEL_MIN);
    localparam logic [DW-1:0] DARK_LIM = DW'(DARK_LIMIT);
    localparam logic [DW-1:0] DARK_SAT = DW'(DARK_LIMIT + 1);

    lamp_state_e   state_q, state_d;
    logic [YW-1:0] yel_q, yel_d;
    logic [DW-1:0] dark_q, dark_d;
    logic [1:0]    lit_cnt;
    lamp_state_e   lit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNK;
            yel_q   <= '0;
            dark_q  <= '0;
        end else begin
            state_q <= state_d;
            yel_q   <= yel_d;
            dark_q  <= dark_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        yel_d     = yel_q;
        dark_d    = dark_q;
        multi_o   = 1'b0;
        dark_o    = 1'b0;
        skip_o    = 1'b0;
        seq_o     = 1'b0;
        short_o   = 1'b0;
        lit_cnt   = {1'b0, red_i} + {1'b0, yel_i} + {1'b0, grn_i};
        lit       = lamp_decode(red_i, yel_i, grn_i);
        one_lit_o = (lit_cnt == 2'd1);
        is_red_o  = one_lit_o && red_i;

        if (lit_cnt > 2'd1) begin
            multi_o = 1'b1;
        end else if (lit_cnt == 2'd0) begin
            dark_o = (dark_q >= DARK_LIM);
            if (dark_q != DARK_SAT) dark_d = dark_q + 1'b1;
        end else begin
            dark_d  = '0;
            state_d = lit;
            unique case (state_q)
                // Yellow duration is unknowable when first seen mid-phase, so it is not judged.
                UNK: yel_d = (lit == YEL) ? YEL_SAT : '0;
                RED: begin
                    yel_d = '0;
                    if (lit == YEL) seq_o = 1'b1;
                end
                GRN: begin
                    yel_d = (lit == YEL) ? YW'(1) : '0;
                    if (lit == RED) skip_o = 1'b1;
                end
                YEL: begin
                    if (lit == YEL) begin
                        if (yel_q != YEL_SAT) yel_d = yel_q + 1'b1;
                    end else begin
                        yel_d = '0;
                        if (lit == RED) short_o = (yel_q < YEL_SAT);
                        else            seq_o   = 1'b1;
                    end
                end
            endcase
        end

        if (clr_i) begin
            state_d = UNK;
            yel_d   = '0;
            dark_d  = '0;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - conflict monitor top: trackers, priority encoder, fault latch, flash drive
// Optional red-flash generator enabled by TRAFFIC_MON_FLASH_EN.
module traffic_conflict_monitor
    import traffic_mon_pkg::*;
#(
    parameter int YEL_MIN    = 4,
    parameter int DARK_LIMIT = 3,
    parameter int FLASH_HALF = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    traffic_conflict_monitor_if.slave    mon_if
);

    logic       ns_one, ns_is_red, ns_multi, ns_dark, ns_skip, ns_seq, ns_short;
    logic       ew_one, ew_is_red, ew_multi, ew_dark, ew_skip, ew_seq, ew_short;
    logic       conflict;
    logic [2:0] cause;
    logic       clr_accept;
    logic       latch_new;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;

    if (FLASH_HALF < 1) begin : g_bad_flash_half
        $error("FLASH_HALF must be at least 1");
    end

    approach_tracker #(.YEL_MIN(YEL_MIN), .DARK_LIMIT(DARK_LIMIT)) u_ns (
        .clk(clk), .rst(rst), .clr_i(clr_accept),
        .red_i(mon_if.ns_red), .yel_i(mon_if.ns_yellow), .grn_i(mon_if.ns_green),
        .one_lit_o(ns_one), .is_red_o(ns_is_red), .multi_o(ns_multi), .dark_o(ns_dark),
        .skip_o(ns_skip), .seq_o(ns_seq), .short_o(ns_short)
    );

    approach_tracker #(.YEL_MIN(YEL_MIN), .DARK_LIMIT(DARK_LIMIT)) u_ew (
        .clk(clk), .rst(rst), .clr_i(clr_accept),
        .red_i(mon_if.ew_red), .yel_i(mon_if.ew_yellow), .grn_i(mon_if.ew_green),
        .one_lit_o(ew_one), .is_red_o(ew_is_red), .multi_o(ew_multi), .dark_o(ew_dark),
        .skip_o(ew_skip), .seq_o(ew_seq), .short_o(ew_short)
    );

    assign conflict = ns_one && ew_one && !ns_is_red && !ew_is_red;

    always_comb begin
        cause = FC_NONE;
        if (conflict)                  cause = FC_CONFLICT;
        else if (ns_multi || ew_multi) cause = FC_MULTI;
        else if (ns_dark  || ew_dark)  cause = FC_DARK;
        else if (ns_skip  || ew_skip)  cause = FC_SKIPYEL;
        else if (ns_seq   || ew_seq)   cause = FC_SEQ;
        else if (ns_short || ew_short) cause = FC_SHORTYEL;
    end

    // A live fault cause always wins over a clear request.
    assign clr_accept = mon_if.fault_clr && (cause == FC_NONE);
    assign latch_new  = !fault_q && (cause != FC_NONE);

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        if (latch_new) begin
            fault_d = 1'b1;
            code_d  = cause;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (clr_accept) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mon_if.fault      = fault_q;
    assign mon_if.fault_code = code_q;
    assign mon_if.fault_cnt  = cnt_q;

`ifdef TRAFFIC_MON_FLASH_EN
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_q, flash_d;

    always_comb begin
        flash_d     = 1'b0;
        flash_cnt_d = '0;
        if (latch_new) begin
            flash_d = 1'b1;
        end else if (fault_q && !clr_accept) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_d = !flash_q;
            end else begin
                flash_d     = flash_q;
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    assign mon_if.flash_red = flash_q;
`else
    assign mon_if.flash_red = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - self-checking bench for traffic_conflict_monitor with reference model
module tb_traffic_conflict_monitor;

    localparam int YEL_MIN    = 4;
    localparam int DARK_LIMIT = 3;
    localparam int FLASH_HALF = 2;
`ifdef TRAFFIC_MON_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_D = 3'b000;

    localparam int S_UNK = 0, S_RED = 1, S_GRN = 2, S_YEL = 3;
    localparam int NO_CAUSE = 7;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    traffic_conflict_monitor_if bus ();

    traffic_conflict_monitor #(
        .YEL_MIN(YEL_MIN), .DARK_LIMIT(DARK_LIMIT), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mon_if(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: expected outputs after the most recent edge.
    int m_st   [2];
    int m_dark [2];
    int m_ycnt [2];
    bit m_fault;
    int m_code;
    int m_cnt;
    int m_since;

    function automatic int lo(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int lamp_state(input logic [2:0] ryg);
        if (ryg == L_R) return S_RED;
        if (ryg == L_G) return S_GRN;
        if (ryg == L_Y) return S_YEL;
        return S_UNK;
    endfunction

    function automatic bit exp_flash();
        return FLASH_ON && m_fault && (((m_since / FLASH_HALF) % 2) == 0);
    endfunction

    task automatic model_eval();
        logic [2:0] lamp [2];
        int nst [2];
        int ndk [2];
        int nyc [2];
        int lit [2];
        int n   [2];
        int cause;
        lamp[0] = {bus.ns_red, bus.ns_yellow, bus.ns_green};
        lamp[1] = {bus.ew_red, bus.ew_yellow, bus.ew_green};
        cause = NO_CAUSE;
        for (int a = 0; a < 2; a++) begin
            n[a]   = $countones(lamp[a]);
            lit[a] = lamp_state(lamp[a]);
            nst[a] = m_st[a];
            ndk[a] = m_dark[a];
            nyc[a] = m_ycnt[a];
            if (n[a] > 1) begin
                cause = lo(cause, 2);
            end else if (n[a] == 0) begin
                ndk[a] = m_dark[a] + 1;
                if (ndk[a] > DARK_LIMIT) cause = lo(cause, 3);
            end else begin
                ndk[a] = 0;
                nst[a] = lit[a];
                nyc[a] = 0;
                if (m_st[a] == S_UNK) begin
                    if (lit[a] == S_YEL) nyc[a] = YEL_MIN;
                end else if (lit[a] == m_st[a]) begin
                    if (lit[a] == S_YEL) nyc[a] = m_ycnt[a] + 1;
                end else if (m_st[a] == S_GRN && lit[a] == S_YEL) begin
                    nyc[a] = 1;
                end else if (m_st[a] == S_YEL && lit[a] == S_RED) begin
                    if (m_ycnt[a] < YEL_MIN) cause = lo(cause, 6);
                end else if (m_st[a] == S_GRN && lit[a] == S_RED) begin
                    cause = lo(cause, 4);
                end else if (!(m_st[a] == S_RED && lit[a] == S_GRN)) begin
                    cause = lo(cause, 5);
                end
            end
        end
        if (n[0] == 1 && n[1] == 1 && lit[0] != S_RED && lit[1] != S_RED) cause = 1;

        if (rst) begin
            m_fault = 0; m_code = 0; m_cnt = 0; m_since = 0;
            for (int a = 0; a < 2; a++) begin
                m_st[a] = S_UNK; m_dark[a] = 0; m_ycnt[a] = 0;
            end
        end else if (cause == NO_CAUSE && bus.fault_clr) begin
            m_fault = 0; m_code = 0; m_since = 0;
            for (int a = 0; a < 2; a++) begin
                m_st[a] = S_UNK; m_dark[a] = 0; m_ycnt[a] = 0;
            end
        end else begin
            if (cause != NO_CAUSE && !m_fault) begin
                m_fault = 1; m_code = cause; m_cnt = lo(m_cnt + 1, 255); m_since = 0;
            end else if (m_fault) begin
                m_since++;
            end
            for (int a = 0; a < 2; a++) begin
                m_st[a] = nst[a]; m_dark[a] = ndk[a]; m_ycnt[a] = nyc[a];
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ns, input logic [2:0] ew);
        {bus.ns_red, bus.ns_yellow, bus.ns_green} = ns;
        {bus.ew_red, bus.ew_yellow, bus.ew_green} = ew;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fault_clr = 1'b0;
        drive(L_D, L_D);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset.fault got=%0b exp=0", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd0) begin n_fail++; $display("FAIL reset.code got=%0d exp=0", bus.fault_code); end
        n_cmp++; if (bus.fault_cnt !== 8'd0) begin n_fail++; $display("FAIL reset.cnt got=%0d exp=0", bus.fault_cnt); end
        n_cmp++; if (bus.flash_red !== 1'b0) begin n_fail++; $display("FAIL reset.flash got=%0b exp=0", bus.flash_red); end
    endtask

    task automatic test_legal_cycle();
        int faults_seen;
        faults_seen = 0;
        do_reset();
        drive(L_R, L_R); tick(); tick();
        for (int i = 0; i < 10; i++) begin drive(L_G, L_R); tick(); faults_seen += bus.fault; end
        for (int i = 0; i < 4;  i++) begin drive(L_Y, L_R); tick(); faults_seen += bus.fault; end
        for (int i = 0; i < 2;  i++) begin drive(L_R, L_R); tick(); faults_seen += bus.fault; end
        for (int i = 0; i < 10; i++) begin drive(L_R, L_G); tick(); faults_seen += bus.fault; end
        for (int i = 0; i < 4;  i++) begin drive(L_R, L_Y); tick(); faults_seen += bus.fault; end
        for (int i = 0; i < 2;  i++) begin drive(L_R, L_R); tick(); faults_seen += bus.fault; end
        n_cmp++; if (faults_seen !== 0) begin n_fail++; $display("FAIL legal.fault_cycles got=%0d exp=0", faults_seen); end
        n_cmp++; if (bus.fault_cnt !== 8'd0) begin n_fail++; $display("FAIL legal.cnt got=%0d exp=0", bus.fault_cnt); end
    endtask

    task automatic test_both_green();
        bit exp;
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_G, L_G); tick();
        n_cmp++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL both_green.fault got=%0b exp=1", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd1) begin n_fail++; $display("FAIL both_green.code got=%0d exp=1", bus.fault_code); end
        n_cmp++; if (bus.fault_cnt !== 8'd1) begin n_fail++; $display("FAIL both_green.cnt got=%0d exp=1", bus.fault_cnt); end
        drive(L_R, L_R);
        for (int k = 0; k < 6; k++) begin
            exp = FLASH_ON && (((k / FLASH_HALF) % 2) == 0);
            n_cmp++; if (bus.flash_red !== exp) begin n_fail++; $display("FAIL both_green.flash[%0d] got=%0b exp=%0b", k, bus.flash_red, exp); end
            tick();
        end
        n_cmp++; if (bus.fault_code !== 3'd1) begin n_fail++; $display("FAIL both_green.code_held got=%0d exp=1", bus.fault_code); end
        n_cmp++; if (bus.fault_cnt !== 8'd1) begin n_fail++; $display("FAIL both_green.cnt_held got=%0d exp=1", bus.fault_cnt); end
    endtask

    task automatic test_short_yellow();
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_G, L_R); tick(); tick();
        drive(L_Y, L_R); tick(); tick(); tick();
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL short_yel.pre_fault got=%0b exp=0", bus.fault); end
        drive(L_R, L_R); tick();
        n_cmp++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL short_yel.fault got=%0b exp=1", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd6) begin n_fail++; $display("FAIL short_yel.code got=%0d exp=6", bus.fault_code); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_G, L_R); tick(); tick();
        drive(L_R | L_Y, L_R); tick();
        n_cmp++; if (bus.fault_code !== 3'd2) begin n_fail++; $display("FAIL simultaneous.code got=%0d exp=2", bus.fault_code); end
    endtask

    task automatic test_dark();
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_R, L_D); tick(); tick(); tick();
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL dark.after3 got=%0b exp=0", bus.fault); end
        tick();
        n_cmp++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL dark.after4 got=%0b exp=1", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd3) begin n_fail++; $display("FAIL dark.code got=%0d exp=3", bus.fault_code); end
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_R, L_D); tick(); tick(); tick();
        drive(L_R, L_R); tick(); tick(); tick();
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL dark.relit got=%0b exp=0", bus.fault); end
    endtask

    task automatic test_clear();
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_G, L_G); tick();
        drive(L_R, L_R); tick(); tick();
        bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL clear.fault got=%0b exp=0", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd0) begin n_fail++; $display("FAIL clear.code got=%0d exp=0", bus.fault_code); end
        n_cmp++; if (bus.fault_cnt !== 8'd1) begin n_fail++; $display("FAIL clear.cnt got=%0d exp=1", bus.fault_cnt); end
        drive(L_G, L_G);
        bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
        n_cmp++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL clear_conflict.fault got=%0b exp=1", bus.fault); end
        n_cmp++; if (bus.fault_code !== 3'd1) begin n_fail++; $display("FAIL clear_conflict.code got=%0d exp=1", bus.fault_code); end
        n_cmp++; if (bus.fault_cnt !== 8'd2) begin n_fail++; $display("FAIL clear_conflict.cnt got=%0d exp=2", bus.fault_cnt); end
    endtask

    task automatic test_reset_mid_yellow();
        do_reset();
        drive(L_R, L_R); tick();
        drive(L_G, L_G); tick();
        drive(L_G, L_R); tick();
        drive(L_Y, L_R); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rst_yel.fault got=%0b exp=0", bus.fault); end
        n_cmp++; if (bus.fault_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_yel.cnt got=%0d exp=0", bus.fault_cnt); end
        n_cmp++; if (bus.flash_red !== 1'b0) begin n_fail++; $display("FAIL rst_yel.flash got=%0b exp=0", bus.flash_red); end
        drive(L_R, L_R); tick(); tick(); tick();
        n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rst_yel.no_short got=%0b exp=0", bus.fault); end
    endtask

    task automatic test_cnt_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(L_G, L_G); tick();
            drive(L_R, L_R); tick();
            bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
        end
        n_cmp++; if (bus.fault_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_sat.cnt got=%0d exp=255", bus.fault_cnt); end
    endtask

    task automatic test_random();
        logic [2:0] seq [3];
        logic [2:0] pat [2];
        int         phase [2];
        int         r;
        seq[0] = L_R; seq[1] = L_G; seq[2] = L_Y;
        do_reset();
        phase[0] = 0; phase[1] = 0;
        pat[0] = L_R; pat[1] = L_R;
        for (int c = 0; c < 3000; c++) begin
            for (int a = 0; a < 2; a++) begin
                r = $urandom_range(0, 99);
                if (r < 8) begin
                    phase[a] = (phase[a] + 1) % 3;
                    pat[a]   = seq[phase[a]];
                end else if (r < 11) begin
                    pat[a] = 3'($urandom_range(0, 7));
                end
            end
            drive(pat[0], pat[1]);
            bus.fault_clr = ($urandom_range(0, 99) < 4);
            rst           = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++; if (bus.fault !== m_fault) begin n_fail++; $display("FAIL random.fault cyc=%0d got=%0b exp=%0b", c, bus.fault, m_fault); end
            n_cmp++; if (bus.fault_code !== 3'(m_code)) begin n_fail++; $display("FAIL random.code cyc=%0d got=%0d exp=%0d", c, bus.fault_code, m_code); end
            n_cmp++; if (bus.fault_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL random.cnt cyc=%0d got=%0d exp=%0d", c, bus.fault_cnt, m_cnt); end
            n_cmp++; if (bus.flash_red !== exp_flash()) begin n_fail++; $display("FAIL random.flash cyc=%0d got=%0b exp=%0b", c, bus.flash_red, exp_flash()); end
        end
        rst = 1'b0;
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.fault_clr = 1'b0;
        drive(L_D, L_D);
        @(posedge clk);
        #1;
        test_reset();
        test_legal_cycle();
        test_both_green();
        test_short_yellow();
        test_simultaneous();
        test_dark();
        test_clear();
        test_reset_mid_yellow();
        test_cnt_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
